song_memory_responder: RTL

Responder end of the tl_* sample-fetch interface used by the game controller. It accepts single-word read and write requests on byte addresses and translates them into transactions on a word-addressed memory port (SDRAM controller / on-chip RAM) that has waitrequest and rdvalid. Each read returns `sample` with a one-cycle `tl_rdv` pulse. Writes are used by the song loader to fill memory before play.

---
 rtl/rockband_tl_pkg.sv | 17 +
 rtl/song_memory_responder_if.sv | 37 +++
 rtl/tl_timeout_counter.sv | 28 ++
 rtl/song_memory_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rockband_tl_pkg.sv
// rtl/rockband_tl_pkg.sv - shared tl_* widths and responder state encoding
package rockband_tl_pkg;

  localparam int TL_AW = 32;
  localparam int TL_DW = 32;
  localparam int TL_BYTE_SHIFT = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RESP,
    GAP
  } resp_state_t;

endpackage

// File: rtl/song_memory_responder_if.sv
// rtl/song_memory_responder_if.sv - tl_* request bus plus word-addressed memory port
interface song_memory_responder_if #(
  parameter int MEM_AW = 22
);

  logic                                 tl_read;
  logic                                 tl_write;
  logic [rockband_tl_pkg::TL_AW-1:0]    tl_addr;
  logic [rockband_tl_pkg::TL_DW-1:0]    tl_wdata;
  logic [rockband_tl_pkg::TL_DW-1:0]    sample;
  logic                                 tl_rdv;
  logic                                 tl_wack;

  logic [MEM_AW-1:0]                    mem_addr;
  logic                                 mem_rd;
  logic                                 mem_wr;
  logic [rockband_tl_pkg::TL_DW-1:0]    mem_wdata;
  logic                                 mem_waitrequest;
  logic [rockband_tl_pkg::TL_DW-1:0]    mem_rdata;
  logic                                 mem_rdvalid;

  // slave: the responder; master: initiator and memory seen from outside
  modport slave (
    input  tl_read, tl_write, tl_addr, tl_wdata,
    output sample, tl_rdv, tl_wack,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_waitrequest, mem_rdata, mem_rdvalid
  );

  modport master (
    output tl_read, tl_write, tl_addr, tl_wdata,
    input  sample, tl_rdv, tl_wack,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_waitrequest, mem_rdata, mem_rdvalid
  );

endinterface

// File: rtl/tl_timeout_counter.sv
// rtl/tl_timeout_counter.sv - read-wait watchdog, expires on the TIMEOUT-th enabled cycle
module tl_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic aud_clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge aud_clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/song_memory_responder.sv
// rtl/song_memory_responder.sv - tl_* sample-fetch responder onto a waitrequest/rdvalid memory port
module song_memory_responder
  import rockband_tl_pkg::*;
#(
  parameter int          MEM_AW       = 22,
  parameter int          DEPTH_WORDS  = 4194304,
  parameter int          BASE_WORD    = 0,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'h0000_0000
) (
  input  logic                    aud_clk,
  input  logic                    Reset,
  song_memory_responder_if.slave  tl,
  output logic                    err_oob,
  output logic                    err_timeout
);

  localparam int                IDX_W   = TL_AW - TL_BYTE_SHIFT;
  localparam logic [32:0]       DEPTH_U = 33'(DEPTH_WORDS);
  localparam logic [MEM_AW-1:0] BASE_U  = MEM_AW'(BASE_WORD);

  resp_state_t       state, next;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [MEM_AW-1:0] word_addr;
  logic              unused_addr_lsbs;

  logic [MEM_AW-1:0] addr_q;
  logic [TL_DW-1:0]  wdata_q;
  logic [TL_DW-1:0]  sample_q;
  logic              rdv_q;
  logic              wack_q;

  logic load_addr, load_wdata, rd_capture, load_default;
  logic set_oob, set_timeout, rdv_set, wack_set;
  logic expired;

  assign idx              = tl.tl_addr[TL_AW-1:TL_BYTE_SHIFT];
  assign unused_addr_lsbs = ^tl.tl_addr[TL_BYTE_SHIFT-1:0];
  assign in_range         = (33'(idx) < DEPTH_U);
  assign word_addr        = idx[MEM_AW-1:0] + BASE_U;

  tl_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .aud_clk (aud_clk),
    .Reset   (Reset),
    .clear   (state != RD_WAIT),
    .enable  (state == RD_WAIT),
    .expired (expired)
  );

  always_ff @(posedge aud_clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next         = state;
    load_addr    = 1'b0;
    load_wdata   = 1'b0;
    rd_capture   = 1'b0;
    load_default = 1'b0;
    set_oob      = 1'b0;
    set_timeout  = 1'b0;
    rdv_set      = 1'b0;
    wack_set     = 1'b0;
    case (state)
      IDLE: begin
        // A simultaneous write request is dropped in favour of the read.
        if (tl.tl_read) begin
          if (in_range) begin
            load_addr = 1'b1;
            next      = RD_REQ;
          end else begin
            load_default = 1'b1;
            set_oob      = 1'b1;
            next         = RESP;
          end
        end else if (tl.tl_write) begin
          if (in_range) begin
            load_addr  = 1'b1;
            load_wdata = 1'b1;
            next       = WR_REQ;
          end else begin
            set_oob  = 1'b1;
            wack_set = 1'b1;
            next     = GAP;
          end
        end
      end
      RD_REQ: begin
        if (!tl.mem_waitrequest) next = RD_WAIT;
      end
      RD_WAIT: begin
        if (tl.mem_rdvalid) begin
          rd_capture = 1'b1;
          next       = RESP;
        end else if (expired) begin
          load_default = 1'b1;
          set_timeout  = 1'b1;
          next         = RESP;
        end
      end
      WR_REQ: begin
        if (!tl.mem_waitrequest) begin
          wack_set = 1'b1;
          next     = GAP;
        end
      end
      RESP: begin
        rdv_set = 1'b1;
        next    = GAP;
      end
      GAP:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge aud_clk or negedge Reset) begin
    if (!Reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      sample_q    <= '0;
      rdv_q       <= 1'b0;
      wack_q      <= 1'b0;
      err_oob     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rdv_q  <= rdv_set;
      wack_q <= wack_set;
      if (load_addr)  addr_q  <= word_addr;
      if (load_wdata) wdata_q <= tl.tl_wdata;
      if (rd_capture) begin
        sample_q <= tl.mem_rdata;
      end else if (load_default) begin
        sample_q <= TIMEOUT_DATA;
      end
      if (set_oob)     err_oob     <= 1'b1;
      if (set_timeout) err_timeout <= 1'b1;
    end
  end

  assign tl.mem_addr  = addr_q;
  assign tl.mem_wdata = wdata_q;
  assign tl.mem_rd    = (state == RD_REQ);
  assign tl.mem_wr    = (state == WR_REQ);
  assign tl.sample    = sample_q;
  assign tl.tl_rdv    = rdv_q;
  assign tl.tl_wack   = wack_q;

endmodule
